// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I OP/OP-IMM decode feeding the ID/EX pipeline register.
// Revision 1.0 - initial release.
`default_nettype none

module id_ex_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int XLEN       = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic                  ReadyD,
  output logic [XLEN-1:0]       OpAE,
  output logic [XLEN-1:0]       OpBE,
  output logic [XLEN-1:0]       ExtImmE,
  output logic [2:0]            ALUFuncE,
  output logic                  OpBSrcE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  RegWriteE,
  output logic                  ValidE,
  output logic                  IllegalE
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [XLEN-1:0]       ext_imm;
    logic [2:0]            alu_func;
    logic                  op_b_src;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  valid;
    logic                  illegal;
  } bundle_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  legal;
  logic [2:0]            func;
  logic                  b_src;
  logic [XLEN-1:0]       imm;
  logic [REG_ADDR_W-1:0] rs2_idx;
  logic [XLEN-1:0]       imm_i;
  logic [XLEN-1:0]       imm_sh;
  bundle_t               decoded;
  bundle_t               bundle_d;
  bundle_t               bundle_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign imm_i  = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_sh = {{(XLEN-5){1'b0}}, InstrD[24:20]};

  always_comb begin
    legal   = 1'b0;
    func    = ALU_ADD;
    b_src   = 1'b0;
    imm     = '0;
    rs2_idx = '0;
    case (opcode)
      OPC_OP: begin
        rs2_idx = InstrD[24:20];
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  func = ALU_ADD;
            3'b111:  func = ALU_AND;
            3'b110:  func = ALU_OR;
            3'b100:  func = ALU_XOR;
            3'b010:  func = ALU_SLT;
            3'b001:  func = ALU_SLL;
            3'b101:  func = ALU_SRL;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal = 1'b1;
          func  = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        b_src = 1'b1;
        imm   = imm_i;
        legal = 1'b1;
        case (funct3)
          3'b000:  func = ALU_ADD;
          3'b111:  func = ALU_AND;
          3'b110:  func = ALU_OR;
          3'b100:  func = ALU_XOR;
          3'b010:  func = ALU_SLT;
          // Shift amount lives in the low rs2 slot; upper bits must be zero (no SRAI).
          3'b001: begin
            func  = ALU_SLL;
            imm   = imm_sh;
            legal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            func  = ALU_SRL;
            imm   = imm_sh;
            legal = (funct7 == 7'b0000000);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    decoded = '0;
    if (ValidD) begin
      decoded.valid   = 1'b1;
      decoded.illegal = ~legal;
      decoded.op_a    = RD1D;
      decoded.op_b    = RD2D;
      decoded.rs1     = InstrD[19:15];
      decoded.rs2     = rs2_idx;
      decoded.rd      = InstrD[11:7];
      if (legal) begin
        decoded.alu_func  = func;
        decoded.op_b_src  = b_src;
        decoded.ext_imm   = imm;
        decoded.reg_write = (InstrD[11:7] != 5'd0);
      end
    end
  end

  // Flush has priority over stall so the hazard unit can squash a held slot.
  always_comb begin
    bundle_d = bundle_q;
    if (FlushE) begin
      bundle_d = '0;
    end else if (!StallE) begin
      bundle_d = decoded;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bundle_q <= '0;
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign ReadyD    = ~StallE;
  assign OpAE      = bundle_q.op_a;
  assign OpBE      = bundle_q.op_b;
  assign ExtImmE   = bundle_q.ext_imm;
  assign ALUFuncE  = bundle_q.alu_func;
  assign OpBSrcE   = bundle_q.op_b_src;
  assign Rs1E      = bundle_q.rs1;
  assign Rs2E      = bundle_q.rs2;
  assign RdE       = bundle_q.rd;
  assign RegWriteE = bundle_q.reg_write;
  assign ValidE    = bundle_q.valid;
  assign IllegalE  = bundle_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven scoreboard bench for id_ex_stage.
`default_nettype none

module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic        ValidD;
  logic [31:0] RD1D, RD2D;
  logic        StallE, FlushE;
  logic        ReadyD;
  logic [31:0] OpAE, OpBE, ExtImmE;
  logic [2:0]  ALUFuncE;
  logic        OpBSrcE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, ValidE, IllegalE;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.REG_ADDR_W(5), .XLEN(32)) dut (
    .CLK(CLK), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .StallE(StallE), .FlushE(FlushE),
    .ReadyD(ReadyD), .OpAE(OpAE), .OpBE(OpBE), .ExtImmE(ExtImmE),
    .ALUFuncE(ALUFuncE), .OpBSrcE(OpBSrcE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ValidE(ValidE), .IllegalE(IllegalE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] rd1, rd2;
    logic [2:0]  func;
    logic        bsrc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, ill;
    logic        chk_regs;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string nm, logic [31:0] instr, logic valid,
                              logic [31:0] rd1, logic [31:0] rd2, logic [2:0] func,
                              logic bsrc, logic [31:0] imm, logic [4:0] rs1,
                              logic [4:0] rs2, logic [4:0] rd, logic rw,
                              logic ill, logic chk_regs);
    vec_t v;
    v.name = nm; v.instr = instr; v.valid = valid; v.rd1 = rd1; v.rd2 = rd2;
    v.func = func; v.bsrc = bsrc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.rw = rw; v.ill = ill; v.chk_regs = chk_regs;
    return v;
  endfunction

  function automatic vec_t zero_vec(string nm);
    return mk(nm, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0,
              1'b0, 1'b0, 1'b1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Expected E contents for a record; a bubble carries zero operands.
  task automatic check_out(vec_t e);
    chk({e.name, ".OpAE"},      OpAE,      e.valid ? e.rd1 : 32'h0);
    chk({e.name, ".OpBE"},      OpBE,      e.valid ? e.rd2 : 32'h0);
    chk({e.name, ".ExtImmE"},   ExtImmE,   e.imm);
    chk({e.name, ".ALUFuncE"},  {29'h0, ALUFuncE}, {29'h0, e.func});
    chk({e.name, ".OpBSrcE"},   {31'h0, OpBSrcE},  {31'h0, e.bsrc});
    chk({e.name, ".RegWriteE"}, {31'h0, RegWriteE}, {31'h0, e.rw});
    chk({e.name, ".ValidE"},    {31'h0, ValidE},    {31'h0, e.valid});
    chk({e.name, ".IllegalE"},  {31'h0, IllegalE},  {31'h0, e.ill});
    if (e.chk_regs) begin
      chk({e.name, ".Rs1E"}, {27'h0, Rs1E}, {27'h0, e.rs1});
      chk({e.name, ".Rs2E"}, {27'h0, Rs2E}, {27'h0, e.rs2});
      chk({e.name, ".RdE"},  {27'h0, RdE},  {27'h0, e.rd});
    end
  endtask

  task automatic drive(vec_t v);
    InstrD = v.instr;
    ValidD = v.valid;
    RD1D   = v.rd1;
    RD2D   = v.rd2;
  endtask

  // Drive at negedge, push expectation, compare 1 ns after the next posedge.
  task automatic apply(vec_t v);
    vec_t e;
    @(negedge CLK);
    drive(v);
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: empty queue, expected 1 entry");
    end else begin
      e = sb.pop_front();
      check_out(e);
    end
  endtask

  initial begin
    vec_t addi, sub_v, e;

    tbl.push_back(mk("addi",  32'hFFF10093, 1, 32'd5,  32'd7,  3'd0, 1, 32'hFFFFFFFF, 5'd2,  5'd0,  5'd1,  1, 0, 1));
    tbl.push_back(mk("sub",   32'h405201B3, 1, 32'h10, 32'h20, 3'd1, 0, 32'h0,        5'd4,  5'd5,  5'd3,  1, 0, 1));
    tbl.push_back(mk("slli",  32'h00339313, 1, 32'h11, 32'h22, 3'd6, 1, 32'h3,        5'd7,  5'd0,  5'd6,  1, 0, 1));
    tbl.push_back(mk("sra",   32'h403150B3, 1, 32'h33, 32'h44, 3'd0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1, 0));
    tbl.push_back(mk("nop",   32'h00000013, 1, 32'h1,  32'h2,  3'd0, 1, 32'h0,        5'd0,  5'd0,  5'd0,  0, 0, 1));
    tbl.push_back(mk("bubble",32'hFFF10093, 0, 32'h55, 32'h66, 3'd0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 0, 1));
    tbl.push_back(mk("and",   32'h007372B3, 1, 32'hF0, 32'h0F, 3'd2, 0, 32'h0,        5'd6,  5'd7,  5'd5,  1, 0, 1));
    tbl.push_back(mk("ori",   32'h7FF4E413, 1, 32'h9,  32'h8,  3'd3, 1, 32'h7FF,      5'd9,  5'd0,  5'd8,  1, 0, 1));
    tbl.push_back(mk("xori",  32'h8005C513, 1, 32'hA,  32'hB,  3'd4, 1, 32'hFFFFF800, 5'd11, 5'd0,  5'd10, 1, 0, 1));
    tbl.push_back(mk("slt",   32'h00E6A633, 1, 32'hC,  32'hD,  3'd5, 0, 32'h0,        5'd13, 5'd14, 5'd12, 1, 0, 1));
    tbl.push_back(mk("srli",  32'h01F0D093, 1, 32'hE,  32'hF,  3'd7, 1, 32'd31,       5'd1,  5'd0,  5'd1,  1, 0, 1));
    tbl.push_back(mk("srai",  32'h4010D093, 1, 32'h1,  32'h1,  3'd0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1, 0));
    tbl.push_back(mk("sltu",  32'h003130B3, 1, 32'h2,  32'h2,  3'd0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1, 0));
    tbl.push_back(mk("lw",    32'h00012083, 1, 32'h3,  32'h3,  3'd0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1, 0));
    tbl.push_back(mk("sll_f7",32'h022090B3, 1, 32'h4,  32'h4,  3'd0, 0, 32'h0,        5'd0,  5'd0,  5'd0,  0, 1, 0));
    tbl.push_back(mk("add_x0",32'h00208033, 1, 32'h5,  32'h6,  3'd0, 0, 32'h0,        5'd1,  5'd2,  5'd0,  0, 0, 1));

    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    InstrD = 32'hFFF10093; ValidD = 1'b1; RD1D = 32'd5; RD2D = 32'd7;
    @(posedge CLK); #1;
    check_out(zero_vec("reset"));
    @(negedge CLK);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Stall: E holds ADDI for three edges while D presents SUB.
    addi  = tbl[0];
    sub_v = tbl[1];
    apply(addi);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      StallE = 1'b1;
      drive(sub_v);
      #1;
      chk("stall.ReadyD", {31'h0, ReadyD}, 32'h0);
      @(posedge CLK); #1;
      addi.name = "stall_hold";
      check_out(addi);
    end
    @(negedge CLK);
    StallE = 1'b0;
    #1;
    chk("unstall.ReadyD", {31'h0, ReadyD}, 32'h1);
    @(posedge CLK); #1;
    check_out(sub_v);

    // Flush together with stall empties E.
    @(negedge CLK);
    StallE = 1'b1; FlushE = 1'b1;
    drive(tbl[2]);
    @(posedge CLK); #1;
    check_out(zero_vec("flush_stall"));
    @(negedge CLK);
    StallE = 1'b0; FlushE = 1'b0;

    // Asynchronous reset between edges, asserted while stalled.
    apply(tbl[6]);
    @(negedge CLK);
    StallE = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_out(zero_vec("async_reset"));
    @(negedge CLK);
    reset = 1'b0; StallE = 1'b0;

    // First load after reset release.
    e = tbl[9];
    e.name = "post_reset";
    apply(e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode half of the execute-stage interface: turns a decode-stage RV32I instruction plus its register-file read data into the registered control and operand bundle the ALU consumes in E.
- Drives the ALU control inputs (ALUFuncE, OpBSrcE, ExtImmE), its operands (OpAE, OpBE) and writeback control.
- Sits between register-file read and the ALU, as the ID/EX pipeline register, with stall and flush control from the hazard unit.

Parameters:
- REG_ADDR_W, 5, register index width.
- XLEN, 32, data width; only 32 is supported.

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- InstrD  input  32  instruction in decode.
- ValidD  input  1  InstrD/RD1D/RD2D carry a real instruction.
- RD1D  input  32  register-file read data for rs1.
- RD2D  input  32  register-file read data for rs2.
- StallE  input  1  hold the E register contents.
- FlushE  input  1  insert a bubble into E.
- ReadyD  output  1  equals ~StallE; D may advance.
- OpAE  output  32  registered RD1D.
- OpBE  output  32  registered RD2D.
- ExtImmE  output  32  registered extended immediate.
- ALUFuncE  output  3  registered ALU function code.
- OpBSrcE  output  1  1 selects ExtImmE, 0 selects OpBE.
- Rs1E, Rs2E, RdE  output  REG_ADDR_W each  registered register indices.
- RegWriteE  output  1  writeback enable.
- ValidE  output  1  E holds a real instruction.
- IllegalE  output  1  E holds an unsupported encoding.

Behaviour:
- Decode is combinational from InstrD. All outputs except ReadyD are registered: 1-cycle latency from D to E.
- Opcodes:
  - 0110011 (OP): OpBSrc=0.
  - 0010011 (OP-IMM): OpBSrc=1.
  - Any other opcode is illegal.
- ALUFunc encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
- Legal OP encodings (funct7, funct3 -> ALUFunc):
  - 0000000,000 -> ADD
  - 0100000,000 -> SUB
  - 0000000,111 -> AND
  - 0000000,110 -> OR
  - 0000000,100 -> XOR
  - 0000000,010 -> SLT
  - 0000000,001 -> SLL
  - 0000000,101 -> SRL
- Legal OP-IMM encodings (funct3 -> ALUFunc):
  - 000 -> ADD
  - 111 -> AND
  - 110 -> OR
  - 100 -> XOR
  - 010 -> SLT
  - 001 -> SLL, only if instr[31:25]=0000000
  - 101 -> SRL, only if instr[31:25]=0000000
- Everything else is illegal: SLTU/SLTIU (funct3 011), SRA/SRAI, and any other funct7.
- Immediates:
  - Non-shift OP-IMM: sign-extend instr[31:20].
  - Shifts: zero-extend instr[24:20].
  - OP: ExtImm=0.
- Register indices: Rs1=instr[19:15], Rd=instr[11:7]. Rs2=instr[24:20] for OP, 0 for OP-IMM.
- RegWrite = legal & ValidD & (Rd!=0).
- Illegal = ValidD & ~legal. An illegal instruction forces ALUFunc=000, OpBSrc=0, ExtImm=0, RegWrite=0; Valid stays 1.
- ValidD=0 loads a bubble: all outputs 0, regardless of InstrD.
- Register update, in priority order:
  1. reset (asynchronous): every registered output = 0.
  2. FlushE: every registered output = 0. FlushE wins over StallE.
  3. StallE: all registered outputs hold.
  4. Otherwise: load the decoded bundle.
- OpAE/OpBE capture RD1D/RD2D unmodified. Forwarding is outside this block.
- Reset asserted mid-stall or mid-flush clears immediately. The first load happens on the first CLK edge after reset deasserts, if not stalled.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), RD1D=5, ValidD=1 -> next edge: ALUFuncE=000, OpBSrcE=1, ExtImmE=0xFFFFFFFF, Rs1E=2, RdE=1, RegWriteE=1, OpAE=5.
- SUB x3,x4,x5 (0x405201B3) -> ALUFuncE=001, OpBSrcE=0, Rs2E=5, RdE=3, ExtImmE=0. SLLI x6,x7,3 (0x00339313) -> ALUFuncE=110, ExtImmE=3.
- SRA x1,x2,x3 (0x403150B3) -> IllegalE=1, ValidE=1, RegWriteE=0, ALUFuncE=000. NOP 0x00000013 -> ValidE=1, RegWriteE=0 (rd=x0).
- Load ADDI, then hold StallE=1 for 3 cycles while InstrD changes -> E outputs constant and ReadyD=0. Deassert -> new instruction appears after 1 edge.
- StallE=1 and FlushE=1 together -> all E outputs 0 next edge. Assert reset asynchronously between edges -> outputs 0 before the next CLK edge.
